neuromorphic_axi_regs: RTL and testbench

NEUROMORPHIC_AXI_REGS -- requirements
Module: neuromorphic_axi_regs

---
 rtl/neuromorphic_axi_regs.sv | 199 +++++++++++++++++++
 tb/tb_neuromorphic_axi_regs.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuromorphic_axi_regs.sv
// AXI4-Lite register bank for the neuromorphic core: RW control registers, a sticky/W1C
// debug event register, read-only live status words and a write-update strobe.
module neuromorphic_axi_regs #(
    parameter int C_ADDR_WIDTH = 9,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESETN,
    input  logic [C_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                        S_AXI_AWVALID,
    output logic                        S_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                        S_AXI_WVALID,
    output logic                        S_AXI_WREADY,
    output logic [1:0]                  S_AXI_BRESP,
    output logic                        S_AXI_BVALID,
    input  logic                        S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                        S_AXI_ARVALID,
    output logic                        S_AXI_ARREADY,
    output logic [C_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                  S_AXI_RRESP,
    output logic                        S_AXI_RVALID,
    input  logic                        S_AXI_RREADY,
    output logic [C_DATA_WIDTH-1:0]     ctrl_reg,
    output logic [C_DATA_WIDTH-1:0]     net_in_reg,
    output logic [C_DATA_WIDTH-1:0]     cfg_reg,
    output logic [C_DATA_WIDTH-1:0]     clk_div_reg,
    input  logic [C_DATA_WIDTH-1:0]     debug_in,
    input  logic [4*C_DATA_WIDTH-1:0]   aux_in,
    output logic                        reg_wr_pulse,
    output logic [3:0]                  reg_wr_idx
);
    localparam int IdxW  = C_ADDR_WIDTH - 2;
    localparam int StrbW = C_DATA_WIDTH / 8;

    localparam logic [IdxW-1:0] IdxCtrl   = IdxW'(0);
    localparam logic [IdxW-1:0] IdxNetIn  = IdxW'(1);
    localparam logic [IdxW-1:0] IdxCfg    = IdxW'(2);
    localparam logic [IdxW-1:0] IdxDebug  = IdxW'(3);
    localparam logic [IdxW-1:0] IdxAux0   = IdxW'(4);
    localparam logic [IdxW-1:0] IdxAux1   = IdxW'(5);
    localparam logic [IdxW-1:0] IdxAux2   = IdxW'(6);
    localparam logic [IdxW-1:0] IdxAux3   = IdxW'(7);
    localparam logic [IdxW-1:0] IdxClkDiv = IdxW'(8);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef enum logic [1:0] {WIdle, WAck, WResp} w_state_e;
    typedef enum logic [1:0] {RIdle, RAck, RData} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic [C_DATA_WIDTH-1:0] ctrl_q, ctrl_d, net_in_q, net_in_d, cfg_q, cfg_d;
    logic [C_DATA_WIDTH-1:0] clk_div_q, clk_div_d, debug_q, debug_d, rdata_q, rdata_d;
    logic [1:0]              bresp_q, bresp_d, rresp_q, rresp_d;
    logic                    wr_pulse_q, wr_pulse_d;
    logic [3:0]              wr_idx_q, wr_idx_d;

    logic [IdxW-1:0]         w_idx, r_idx;
    logic [C_DATA_WIDTH-1:0] wr_mask, wr_old, wr_merged, dbg_clr;
    logic                    unused_addr_lsbs;

    assign w_idx = S_AXI_AWADDR[C_ADDR_WIDTH-1:2];
    assign r_idx = S_AXI_ARADDR[C_ADDR_WIDTH-1:2];
    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < StrbW; b++) begin
            wr_mask[8*b +: 8] = {8{S_AXI_WSTRB[b]}};
        end
        case (w_idx)
            IdxCtrl:   wr_old = ctrl_q;
            IdxNetIn:  wr_old = net_in_q;
            IdxCfg:    wr_old = cfg_q;
            IdxClkDiv: wr_old = clk_div_q;
            default:   wr_old = '0;
        endcase
        wr_merged = (wr_old & ~wr_mask) | (S_AXI_WDATA & wr_mask);
    end

    // Write path: the handshake cycle (WAck) is also the commit cycle.
    always_comb begin
        w_state_d  = w_state_q;
        bresp_d    = bresp_q;
        wr_pulse_d = 1'b0;
        wr_idx_d   = wr_idx_q;
        ctrl_d     = ctrl_q;
        net_in_d   = net_in_q;
        cfg_d      = cfg_q;
        clk_div_d  = clk_div_q;
        dbg_clr    = '0;
        case (w_state_q)
            WIdle: if (S_AXI_AWVALID && S_AXI_WVALID) w_state_d = WAck;
            WAck: begin
                w_state_d = WResp;
                bresp_d   = (w_idx <= IdxClkDiv) ? RespOkay : RespSlvErr;
                case (w_idx)
                    IdxCtrl:   ctrl_d   = wr_merged;
                    IdxNetIn:  net_in_d = wr_merged;
                    IdxCfg:    cfg_d    = wr_merged;
                    IdxDebug:  dbg_clr  = S_AXI_WDATA & wr_mask;
                    // A zero divider would stall the core clock, so it is clamped to 1.
                    IdxClkDiv: clk_div_d = (wr_merged == '0) ? C_DATA_WIDTH'(1) : wr_merged;
                    default:   ;
                endcase
                if (w_idx inside {IdxCtrl, IdxNetIn, IdxCfg, IdxDebug, IdxClkDiv}) begin
                    wr_pulse_d = 1'b1;
                    wr_idx_d   = w_idx[3:0];
                end
            end
            WResp: if (S_AXI_BREADY) w_state_d = WIdle;
            default: w_state_d = WIdle;
        endcase
        // New events win over a same-cycle clear.
        debug_d = (debug_q & ~dbg_clr) | debug_in;
    end

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            RIdle: if (S_AXI_ARVALID) r_state_d = RAck;
            RAck: begin
                r_state_d = RData;
                rresp_d   = RespOkay;
                case (r_idx)
                    IdxCtrl:   rdata_d = ctrl_q;
                    IdxNetIn:  rdata_d = net_in_q;
                    IdxCfg:    rdata_d = cfg_q;
                    IdxDebug:  rdata_d = debug_q;
                    IdxAux0:   rdata_d = aux_in[0*C_DATA_WIDTH +: C_DATA_WIDTH];
                    IdxAux1:   rdata_d = aux_in[1*C_DATA_WIDTH +: C_DATA_WIDTH];
                    IdxAux2:   rdata_d = aux_in[2*C_DATA_WIDTH +: C_DATA_WIDTH];
                    IdxAux3:   rdata_d = aux_in[3*C_DATA_WIDTH +: C_DATA_WIDTH];
                    IdxClkDiv: rdata_d = clk_div_q;
                    default: begin
                        rdata_d = '0;
                        rresp_d = RespSlvErr;
                    end
                endcase
            end
            RData: if (S_AXI_RREADY) r_state_d = RIdle;
            default: r_state_d = RIdle;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            w_state_q  <= WIdle;
            r_state_q  <= RIdle;
            ctrl_q     <= '0;
            net_in_q   <= '0;
            cfg_q      <= '0;
            clk_div_q  <= C_DATA_WIDTH'(1);
            debug_q    <= '0;
            rdata_q    <= '0;
            bresp_q    <= '0;
            rresp_q    <= '0;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            ctrl_q     <= ctrl_d;
            net_in_q   <= net_in_d;
            cfg_q      <= cfg_d;
            clk_div_q  <= clk_div_d;
            debug_q    <= debug_d;
            rdata_q    <= rdata_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            wr_pulse_q <= wr_pulse_d;
            wr_idx_q   <= wr_idx_d;
        end
    end

    assign S_AXI_AWREADY = (w_state_q == WAck);
    assign S_AXI_WREADY  = (w_state_q == WAck);
    assign S_AXI_BVALID  = (w_state_q == WResp);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = (r_state_q == RAck);
    assign S_AXI_RVALID  = (r_state_q == RData);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    assign ctrl_reg     = ctrl_q;
    assign net_in_reg   = net_in_q;
    assign cfg_reg      = cfg_q;
    assign clk_div_reg  = clk_div_q;
    assign reg_wr_pulse = wr_pulse_q;
    assign reg_wr_idx   = wr_idx_q;

endmodule

// File: tb/tb_neuromorphic_axi_regs.sv
// Randomized bench for neuromorphic_axi_regs against a word-level register-map model.
module tb_neuromorphic_axi_regs;
    logic         clk = 1'b0;
    logic         aresetn;
    logic [8:0]   awaddr, araddr;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [31:0]  ctrl_reg, net_in_reg, cfg_reg, clk_div_reg, debug_in;
    logic [127:0] aux_in;
    logic         reg_wr_pulse;
    logic [3:0]   reg_wr_idx;

    int n_checks = 0;
    int n_errors = 0;

    // Model: words 0..8 of the map; entries 4..7 unused (aux is read live from aux_in).
    logic [31:0] m_reg [0:8];

    always #5 clk = ~clk;

    neuromorphic_axi_regs dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (aresetn),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .ctrl_reg      (ctrl_reg),
        .net_in_reg    (net_in_reg),
        .cfg_reg       (cfg_reg),
        .clk_div_reg   (clk_div_reg),
        .debug_in      (debug_in),
        .aux_in        (aux_in),
        .reg_wr_pulse  (reg_wr_pulse),
        .reg_wr_idx    (reg_wr_idx)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i <= 8; i++) m_reg[i] = 32'h0;
        m_reg[8] = 32'h1;
    endtask

    task automatic model_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                               input logic [31:0] dbg, output logic [1:0] resp,
                               output logic pulse);
        int idx;
        logic [31:0] mask;
        logic [31:0] nv;
        idx = int'(a) / 4;
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = s[b] ? 8'hFF : 8'h00;
        resp  = (idx > 8) ? 2'b10 : 2'b00;
        pulse = (idx <= 3) || (idx == 8);
        if (idx == 3) begin
            m_reg[3] = m_reg[3] & ~(d & mask);
        end else if (pulse) begin
            nv = (m_reg[idx] & ~mask) | (d & mask);
            if (idx == 8 && nv == 0) nv = 1;
            m_reg[idx] = nv;
        end
        m_reg[3] = m_reg[3] | dbg;
    endtask

    task automatic model_read(input logic [8:0] a, output logic [31:0] d, output logic [1:0] resp);
        int idx;
        idx = int'(a) / 4;
        resp = 2'b00;
        if (idx > 8) begin
            d = 0;
            resp = 2'b10;
        end else if (idx >= 4 && idx <= 7) begin
            d = aux_in[(idx-4)*32 +: 32];
        end else begin
            d = m_reg[idx];
        end
    endtask

    // dbg is driven on debug_in during the commit cycle only.
    task automatic axi_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [31:0] dbg, input int hold);
        logic [1:0] er;
        logic ep;
        int waited;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!awready && waited < 20);
        if (!awready) begin
            check_eq("aw_timeout", 32'(awready), 32'h1);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        check_eq("wready_with_awready", 32'(wready), 32'h1);
        debug_in = dbg;
        model_write(a, d, s, dbg, er, ep);
        @(negedge clk);
        debug_in = 0; awvalid = 1'b0; wvalid = 1'b0;
        check_eq("awready_one_cycle", 32'(awready), 32'h0);
        check_eq("wready_one_cycle", 32'(wready), 32'h0);
        check_eq("bvalid", 32'(bvalid), 32'h1);
        check_eq("bresp", 32'(bresp), 32'(er));
        check_eq("wr_pulse", 32'(reg_wr_pulse), 32'(ep));
        if (ep) check_eq("wr_idx", 32'(reg_wr_idx), 32'(a[5:2]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("bvalid_hold", 32'(bvalid), 32'h1);
            check_eq("bresp_hold", 32'(bresp), 32'(er));
            check_eq("wr_pulse_drop", 32'(reg_wr_pulse), 32'h0);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check_eq("bvalid_done", 32'(bvalid), 32'h0);
    endtask

    task automatic axi_read(input logic [8:0] a, input int hold);
        logic [31:0] ed;
        logic [1:0] er;
        int waited;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!arready && waited < 20);
        if (!arready) begin
            check_eq("ar_timeout", 32'(arready), 32'h1);
            arvalid = 1'b0;
            return;
        end
        model_read(a, ed, er);
        @(negedge clk);
        arvalid = 1'b0;
        check_eq("arready_one_cycle", 32'(arready), 32'h0);
        check_eq("rvalid", 32'(rvalid), 32'h1);
        check_eq($sformatf("rdata@%03h", a), rdata, ed);
        check_eq($sformatf("rresp@%03h", a), 32'(rresp), 32'(er));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("rvalid_hold", 32'(rvalid), 32'h1);
            check_eq("rdata_hold", rdata, ed);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check_eq("rvalid_done", 32'(rvalid), 32'h0);
    endtask

    task automatic check_outputs();
        check_eq("ctrl_reg", ctrl_reg, m_reg[0]);
        check_eq("net_in_reg", net_in_reg, m_reg[1]);
        check_eq("cfg_reg", cfg_reg, m_reg[2]);
        check_eq("clk_div_reg", clk_div_reg, m_reg[8]);
    endtask

    initial begin
        logic [31:0] old_v;
        logic [1:0]  er;
        logic        ep;
        logic [8:0]  a;
        logic [6:0]  idx7;
        int          waited;
        int          pick;

        aresetn = 1'b0;
        awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        araddr = 0; arvalid = 0; rready = 0; debug_in = 0;
        aux_in = {$urandom, $urandom, $urandom, $urandom};
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_awready", 32'(awready), 32'h0);
        check_eq("rst_bvalid", 32'(bvalid), 32'h0);
        check_eq("rst_arready", 32'(arready), 32'h0);
        check_eq("rst_rvalid", 32'(rvalid), 32'h0);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_wr_pulse", 32'(reg_wr_pulse), 32'h0);
        check_outputs();
        aresetn = 1'b1;

        // Full-word RW registers
        for (int i = 0; i < 4; i++) begin
            a = (i == 3) ? 9'h020 : 9'(i * 4);
            axi_write(a, 32'hDEADBEEF, 4'hF, 32'h0, 0);
            axi_read(a, 0);
        end
        check_outputs();

        // Sticky/W1C debug register, including set winning over clear
        @(negedge clk); debug_in = 32'h5;
        @(negedge clk); debug_in = 32'h0;
        m_reg[3] = m_reg[3] | 32'h5;
        axi_read(9'h00C, 0);
        axi_write(9'h00C, 32'h4, 4'hF, 32'h0, 0);
        axi_read(9'h00C, 0);
        axi_write(9'h00C, 32'h4, 4'hF, 32'h4, 0);
        axi_read(9'h00C, 0);

        // Read-only live status
        aux_in[63:32] = 32'h12345678;
        axi_read(9'h014, 0);
        axi_write(9'h014, 32'h0, 4'hF, 32'h0, 0);
        axi_read(9'h014, 0);

        // Unmapped, divider clamp, byte strobes, empty strobe
        axi_write(9'h024, 32'hFFFFFFFF, 4'hF, 32'h0, 0);
        axi_read(9'h024, 0);
        axi_write(9'h1FC, 32'h12345678, 4'hF, 32'h0, 0);
        axi_read(9'h1FF, 0);
        axi_write(9'h020, 32'h0, 4'hF, 32'h0, 0);
        axi_read(9'h020, 0);
        axi_write(9'h000, 32'h0, 4'hF, 32'h0, 0);
        axi_write(9'h000, 32'h000000FF, 4'b0001, 32'h0, 0);
        axi_read(9'h000, 0);
        axi_write(9'h008, 32'h11111111, 4'h0, 32'h0, 0);
        axi_read(9'h008, 0);

        // Back-pressure on both response channels
        axi_write(9'h004, 32'hCAFE0001, 4'hF, 32'h0, 5);
        axi_read(9'h004, 5);

        // A lone address or a lone data beat must not be accepted
        @(negedge clk); awaddr = 9'h000; awvalid = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("aw_alone_stalls", 32'(awready), 32'h0);
        awvalid = 1'b0; wvalid = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("w_alone_stalls", 32'(wready), 32'h0);
        wvalid = 1'b0;

        // Read capture in the same cycle as a write commit sees the old value
        @(negedge clk);
        awaddr = 9'h000; wdata = 32'hA5A50001; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 9'h000; arvalid = 1'b1;
        old_v = m_reg[0];
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!awready && waited < 20);
        check_eq("concurrent_awready", 32'(awready), 32'h1);
        check_eq("concurrent_arready", 32'(arready), 32'h1);
        model_write(9'h000, 32'hA5A50001, 4'hF, 32'h0, er, ep);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check_eq("concurrent_rdata_old", rdata, old_v);
        check_eq("concurrent_bvalid", 32'(bvalid), 32'h1);
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        check_eq("concurrent_bdone", 32'(bvalid), 32'h0);
        check_eq("concurrent_rdone", 32'(rvalid), 32'h0);
        axi_read(9'h000, 0);

        // Reset during the commit cycle abandons the write
        @(negedge clk);
        awaddr = 9'h000; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!awready && waited < 20);
        check_eq("rst_mid_awready", 32'(awready), 32'h1);
        aresetn = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        model_reset();
        check_eq("rst_mid_awready_low", 32'(awready), 32'h0);
        check_eq("rst_mid_bvalid", 32'(bvalid), 32'h0);
        check_eq("rst_mid_pulse", 32'(reg_wr_pulse), 32'h0);
        check_outputs();
        aresetn = 1'b1;
        axi_read(9'h000, 0);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            aux_in = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk); debug_in = $urandom;
                m_reg[3] = m_reg[3] | debug_in;
                @(negedge clk); debug_in = 32'h0;
            end
            pick = $urandom_range(0, 10);
            if (pick <= 8) idx7 = 7'(pick);
            else idx7 = 7'($urandom_range(9, 127));
            a = {idx7, 2'($urandom)};
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, (pick == 8 && $urandom_range(0, 2) == 0) ? 32'h0 : $urandom,
                          4'($urandom), 32'h0, $urandom_range(0, 2));
            end else begin
                axi_read(a, $urandom_range(0, 2));
            end
            check_outputs();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
